// File: rtl/bias_z_collector.sv
// bias_z_collector
// Collects the skewed per-column bias_z stream and rebuilds whole rows.
// Each column has a small first-word-fall-through lane FIFO that absorbs the
// systolic diagonal skew. When every lane holds at least one entry, the heads
// are popped together and registered as one output row. The row leaves over
// a valid/ready handshake. A row counter flags the last row of a tile, and a
// sticky flag reports any lane that had to drop a push.
module bias_z_collector #(
   parameter int N      = 4,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N*DATA_W-1:0] z_data_in,
   input  logic [N-1:0]        z_valid_in,
   input  logic [15:0]         cfg_rows,
   output logic [N*DATA_W-1:0] row_data_out,
   output logic                row_valid_out,
   input  logic                row_ready_in,
   output logic                row_last_out,
   output logic                overflow_err
);

   // A single-entry lane still needs a 1-bit pointer.
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   // Per-lane status, gathered from the lane generate block.
   logic [N-1:0]        lane_empty;
   logic [N-1:0]        lane_drop;
   logic [N*DATA_W-1:0] head_flat;

   // Row assembly control.
   logic                row_ready_int;
   logic                load;
   logic                accept;

   // Output-side registers.
   logic [N*DATA_W-1:0] row_data_reg;
   logic                row_valid_reg;
   logic                row_last_reg;
   logic                overflow_reg;
   logic [15:0]         row_cnt_reg;
   logic [15:0]         row_cnt_next;
   logic                row_last_next;

   // A row can be formed once every lane has data. It loads when the output
   // register is empty or is being drained on this same edge, so a steady
   // stream flows with no bubbles.
   assign row_ready_int = (lane_empty == '0);
   assign accept        = row_valid_reg && row_ready_in;
   assign load          = row_ready_int && (!row_valid_reg || row_ready_in);

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : gen_lane
         logic [DATA_W-1:0] mem [DEPTH];
         logic [AW-1:0]     wr_ptr_reg;
         logic [AW-1:0]     rd_ptr_reg;
         logic [AW:0]       count_reg;
         logic              lane_full;
         logic              push_ok;

         // A full lane still takes a push if the row load frees a slot
         // on this same edge. Otherwise the push is lost.
         assign lane_full     = (count_reg == DEPTH_CNT);
         assign push_ok       = z_valid_in[gi] && (!lane_full || load);
         assign lane_drop[gi] = z_valid_in[gi] && lane_full && !load;
         assign lane_empty[gi] = (count_reg == '0);

         // The head is read combinationally. This lets a row load on the
         // cycle after its last element arrives.
         assign head_flat[gi*DATA_W +: DATA_W] = mem[rd_ptr_reg];

         // Lane storage write. The data is kept bit-exact.
         always_ff @(posedge clk) begin
            if (rst && push_ok) begin
               mem[wr_ptr_reg] <= z_data_in[gi*DATA_W +: DATA_W];
            end
         end

         // Lane pointers and occupancy. Every lane pops together on a row load.
         always_ff @(posedge clk) begin
            if (!rst) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
            end else begin
               if (push_ok) begin
                  wr_ptr_reg <= wr_ptr_reg + AW'(1);
               end
               if (load) begin
                  rd_ptr_reg <= rd_ptr_reg + AW'(1);
               end
               case ({push_ok, load})
                  2'b10:   count_reg <= count_reg + (AW+1)'(1);
                  2'b01:   count_reg <= count_reg - (AW+1)'(1);
                  default: count_reg <= count_reg;
               endcase
            end
         end
      end
   endgenerate

   // Row counter update and the last-row tag for the row being loaded.
   // If the current row is accepted on this edge, the incoming row takes the
   // next index. Otherwise it takes the current index. In both cases that
   // index is row_cnt_next.
   always_comb begin
      row_cnt_next = row_cnt_reg;
      if (accept) begin
         row_cnt_next = row_last_reg ? 16'd0 : row_cnt_reg + 16'd1;
      end
      row_last_next = (cfg_rows != 16'd0) && (row_cnt_next == cfg_rows - 16'd1);
   end

   // Output row register, row counter and the sticky overflow flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         row_data_reg  <= '0;
         row_valid_reg <= 1'b0;
         row_last_reg  <= 1'b0;
         row_cnt_reg   <= 16'd0;
         overflow_reg  <= 1'b0;
      end else begin
         if (load) begin
            row_data_reg  <= head_flat;
            row_valid_reg <= 1'b1;
            row_last_reg  <= row_last_next;
         end else if (accept) begin
            row_valid_reg <= 1'b0;
            row_last_reg  <= 1'b0;
         end
         row_cnt_reg <= row_cnt_next;
         if (lane_drop != '0) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   assign row_data_out  = row_data_reg;
   assign row_valid_out = row_valid_reg;
   assign row_last_out  = row_last_reg;
   assign overflow_err  = overflow_reg;

endmodule

// File: tb/tb_bias_z_collector.sv
// Testbench for bias_z_collector. Directed vectors are stored in a table and
// applied one per clock, followed by a hand-written mid-tile reset and latency
// sequence.
module tb_bias_z_collector;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] z_data_in;
   logic [3:0]   z_valid_in;
   logic [15:0]  cfg_rows;
   logic [127:0] row_data_out;
   logic         row_valid_out;
   logic         row_ready_in;
   logic         row_last_out;
   logic         overflow_err;

   int checks   = 0;
   int failures = 0;

   bias_z_collector #(.N(4), .DATA_W(32), .DEPTH(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .z_data_in     (z_data_in),
      .z_valid_in    (z_valid_in),
      .cfg_rows      (cfg_rows),
      .row_data_out  (row_data_out),
      .row_valid_out (row_valid_out),
      .row_ready_in  (row_ready_in),
      .row_last_out  (row_last_out),
      .overflow_err  (overflow_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         rst_n;
      logic [3:0]   vld;
      logic [127:0] din;
      logic         rdy;
      logic [15:0]  cfg;
      logic         e_valid;
      logic         e_last;
      logic         e_ovf;
      logic         e_chkdata;
      logic [127:0] e_data;
   } vec_t;

   vec_t tbl[$];

   // Packs four lanes into one row, with lane 0 in the low bits.
   function automatic logic [127:0] pk(input int a, input int b, input int c, input int d);
      logic [31:0] la, lb, lc, ld;
      la = a; lb = b; lc = c; ld = d;
      return {ld, lc, lb, la};
   endfunction

   task automatic add(input logic rst_n, input logic [3:0] vld, input logic [127:0] din,
                      input logic rdy, input logic [15:0] cfg, input logic ev, input logic el,
                      input logic eo, input logic ecd, input logic [127:0] ed);
      vec_t v;
      v.rst_n = rst_n; v.vld = vld; v.din = din; v.rdy = rdy; v.cfg = cfg;
      v.e_valid = ev; v.e_last = el; v.e_ovf = eo; v.e_chkdata = ecd; v.e_data = ed;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s vec=%0d act=%h exp=%h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic rst_n, input logic [3:0] vld, input logic [127:0] din,
                        input logic rdy, input logic [15:0] cfg);
      rst = rst_n; z_valid_in = vld; z_data_in = din; row_ready_in = rdy; cfg_rows = cfg;
   endtask

   initial begin
      logic [127:0] r0;
      int lat;
      logic got;
      r0 = pk(-5, 20, -70, 40);
      drive(1'b0, 4'h0, '0, 1'b1, 16'd1);

      // Reset with inputs active is ignored.
      add(0, 4'hF, pk(7,7,7,7), 1, 1, 0, 0, 0, 1, '0);
      add(0, 4'hF, pk(7,7,7,7), 1, 1, 0, 0, 0, 1, '0);
      add(1, 4'h0, '0, 1, 1, 0, 0, 0, 0, '0);
      add(1, 4'h0, '0, 1, 1, 0, 0, 0, 0, '0);
      // Skewed single row, cfg_rows=1.
      add(1, 4'h1, pk(10,0,0,0), 1, 1, 0, 0, 0, 0, '0);
      add(1, 4'h2, pk(0,11,0,0), 1, 1, 0, 0, 0, 0, '0);
      add(1, 4'h4, pk(0,0,12,0), 1, 1, 0, 0, 0, 0, '0);
      add(1, 4'h8, pk(0,0,0,13), 1, 1, 0, 0, 0, 0, '0);
      add(1, 4'h0, '0, 1, 1, 1, 1, 0, 1, pk(10,11,12,13));
      add(1, 4'h0, '0, 1, 1, 0, 0, 0, 0, '0);
      add(1, 4'h0, '0, 1, 1, 0, 0, 0, 0, '0);
      // Skewed streaming of signed rows, cfg_rows=3.
      add(1, 4'h1, r0, 1, 3, 0, 0, 0, 0, '0);
      add(1, 4'h3, r0, 1, 3, 0, 0, 0, 0, '0);
      add(1, 4'h7, r0, 1, 3, 0, 0, 0, 0, '0);
      add(1, 4'hE, r0, 1, 3, 0, 0, 0, 0, '0);
      add(1, 4'hC, r0, 1, 3, 1, 0, 0, 1, r0);
      add(1, 4'h8, r0, 1, 3, 1, 0, 0, 1, r0);
      add(1, 4'h0, r0, 1, 3, 1, 1, 0, 1, r0);
      add(1, 4'h0, r0, 1, 3, 0, 0, 0, 0, '0);
      add(1, 4'h0, r0, 1, 3, 0, 0, 0, 0, '0);
      // Backpressure. With cfg_rows=1, last=1 confirms the counter is back at 0.
      add(1, 4'hF, pk(1,2,3,4), 0, 1, 0, 0, 0, 0, '0);
      add(1, 4'hF, pk(5,6,7,8), 0, 1, 1, 1, 0, 1, pk(1,2,3,4));
      add(1, 4'h0, '0, 0, 1, 1, 1, 0, 1, pk(1,2,3,4));
      add(1, 4'h0, '0, 0, 1, 1, 1, 0, 1, pk(1,2,3,4));
      add(1, 4'h0, '0, 1, 1, 1, 1, 0, 1, pk(5,6,7,8));
      add(1, 4'h0, '0, 1, 1, 0, 0, 0, 0, '0);
      add(1, 4'h0, '0, 1, 1, 0, 0, 0, 0, '0);
      // Overflow on lane 0, cfg_rows=0 (last never asserts).
      for (int i = 0; i < 6; i++) begin
         add(1, 4'h1, pk(100+i,0,0,0), 0, 0, 0, 0, (i >= 4), 0, '0);
      end
      add(1, 4'hE, pk(0,11,12,13), 1, 0, 0, 0, 1, 0, '0);
      add(1, 4'hE, pk(0,21,22,23), 1, 0, 1, 0, 1, 1, pk(100,11,12,13));
      add(1, 4'hE, pk(0,31,32,33), 1, 0, 1, 0, 1, 1, pk(101,21,22,23));
      add(1, 4'hE, pk(0,41,42,43), 1, 0, 1, 0, 1, 1, pk(102,31,32,33));
      add(1, 4'h0, '0, 1, 0, 1, 0, 1, 1, pk(103,41,42,43));
      add(1, 4'hE, pk(0,51,52,53), 1, 0, 0, 0, 1, 0, '0);
      add(1, 4'h0, '0, 1, 0, 0, 0, 1, 0, '0);
      add(0, 4'h0, '0, 1, 0, 0, 0, 0, 1, '0);
      add(1, 4'h0, '0, 1, 0, 0, 0, 0, 0, '0);
      // A full lane 3 is pushed while a load pops it.
      for (int i = 0; i < 4; i++) begin
         add(1, 4'h8, pk(0,0,0,60+i), 1, 0, 0, 0, 0, 0, '0);
      end
      add(1, 4'h7, pk(1,2,3,0), 1, 0, 0, 0, 0, 0, '0);
      add(1, 4'h8, pk(0,0,0,99), 1, 0, 1, 0, 0, 1, pk(1,2,3,60));
      add(1, 4'h7, pk(4,5,6,0), 1, 0, 0, 0, 0, 0, '0);
      add(1, 4'h7, pk(7,8,9,0), 1, 0, 1, 0, 0, 1, pk(4,5,6,61));
      add(1, 4'h7, pk(10,11,12,0), 1, 0, 1, 0, 0, 1, pk(7,8,9,62));
      add(1, 4'h7, pk(13,14,15,0), 1, 0, 1, 0, 0, 1, pk(10,11,12,63));
      add(1, 4'h0, '0, 1, 0, 1, 0, 0, 1, pk(13,14,15,99));
      add(1, 4'h0, '0, 1, 0, 0, 0, 0, 0, '0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst_n, tbl[i].vld, tbl[i].din, tbl[i].rdy, tbl[i].cfg);
         @(posedge clk);
         #1;
         $display("vec %0d rst=%b vld=%h rdy=%b -> valid=%b last=%b ovf=%b data=%h",
                  i, tbl[i].rst_n, tbl[i].vld, tbl[i].rdy, row_valid_out, row_last_out,
                  overflow_err, row_data_out);
         chk("valid", i, 128'(row_valid_out), 128'(tbl[i].e_valid));
         chk("last", i, 128'(row_last_out), 128'(tbl[i].e_last));
         chk("ovf", i, 128'(overflow_err), 128'(tbl[i].e_ovf));
         if (tbl[i].e_chkdata) begin
            chk("data", i, row_data_out, tbl[i].e_data);
         end
      end

      // Mid-tile reset discards a pending row and a partial row.
      drive(1, 4'hF, pk(1,2,3,4), 0, 1);
      @(posedge clk); #1;
      drive(1, 4'h3, pk(9,9,0,0), 0, 1);
      @(posedge clk); #1;
      chk("pend_valid", 100, 128'(row_valid_out), 128'(1));
      drive(0, 4'h0, '0, 0, 1);
      @(posedge clk); #1;
      chk("rst_valid", 101, 128'(row_valid_out), 128'(0));
      drive(1, 4'hC, pk(0,0,9,9), 1, 1);
      @(posedge clk); #1;
      chk("norow_a", 102, 128'(row_valid_out), 128'(0));
      drive(1, 4'h0, '0, 1, 1);
      @(posedge clk); #1;
      chk("norow_b", 103, 128'(row_valid_out), 128'(0));
      $display("seq reset-mid-tile valid=%b", row_valid_out);

      // Completing the row gives a valid output one edge after the final push.
      drive(1, 4'h3, pk(21,22,0,0), 1, 1);
      @(posedge clk); #1;
      drive(1, 4'h0, '0, 1, 1);
      lat = 0;
      got = 1'b0;
      for (int c = 0; c < 4 && !got; c++) begin
         @(posedge clk); #1;
         lat++;
         if (row_valid_out) got = 1'b1;
      end
      chk("lat_seen", 104, 128'(got), 128'(1));
      chk("lat_cycles", 105, 128'(lat), 128'(1));
      chk("lat_data", 106, row_data_out, pk(21,22,9,9));
      chk("lat_last", 107, 128'(row_last_out), 128'(1));
      $display("seq latency lat=%0d data=%h last=%b", lat, row_data_out, row_last_out);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
